min_second_min_serial_cnu: RTL

MIN_SECOND_MIN_SERIAL_CNU -- requirements
Module: min_second_min_serial_cnu

---
 rtl/min_second_min_serial_cnu_if.sv | 37 +++
 rtl/min_second_min_serial_cnu.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/min_second_min_serial_cnu_if.sv
`default_nettype none
// ============================================================================
//  Module   : min_second_min_serial_cnu_if
//  Purpose  : Bundle of the row handshake (start / in_valid / in_data) and the
//             result bus of the serial min / second-min check-node unit.
//  Ports    : start, in_valid, in_data       driven by the master (producer)
//             busy, done, min_mag, second_mag,
//             min_pos, sign_prod             driven by the slave (CNU)
//  Revision : 1.0 - initial release
// ============================================================================
interface min_second_min_serial_cnu_if #(
  parameter int DEG = 6,
  parameter int W   = 32
);
  localparam int IDX_W = (DEG > 1) ? $clog2(DEG) : 1;

  logic             start;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             busy;
  logic             done;
  logic [W-2:0]     min_mag;
  logic [W-2:0]     second_mag;
  logic [IDX_W-1:0] min_pos;
  logic             sign_prod;

  modport master (
    output start, in_valid, in_data,
    input  busy, done, min_mag, second_mag, min_pos, sign_prod
  );

  modport slave (
    input  start, in_valid, in_data,
    output busy, done, min_mag, second_mag, min_pos, sign_prod
  );
endinterface
`default_nettype wire

// File: rtl/min_second_min_serial_cnu.sv
`default_nettype none
// ============================================================================
//  Module   : min_second_min_serial_cnu
//  Purpose  : Serial check-node unit. Accepts DEG sign-magnitude messages one
//             per valid beat and reports the smallest magnitude, its edge
//             index, the second-smallest magnitude and the XOR of all signs.
//  Ports    : clk        rising-edge clock
//             rst_n      asynchronous active-low reset
//             bus        slave side of min_second_min_serial_cnu_if
//                        (start, in_valid, in_data in; busy, done, min_mag,
//                        second_mag, min_pos, sign_prod out)
//  Revision : 1.0 - initial release
// ============================================================================
module min_second_min_serial_cnu #(
  parameter int DEG = 6,
  parameter int W   = 32
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  min_second_min_serial_cnu_if.slave  bus
);

  localparam int               IDX_W  = (DEG > 1) ? $clog2(DEG) : 1;
  localparam logic [IDX_W-1:0] c_last = IDX_W'(DEG - 1);
  localparam logic [W-2:0]     c_ones = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_cnt;
  logic [W-2:0]     r_min;
  logic [W-2:0]     r_second;
  logic [IDX_W-1:0] r_pos;
  logic             r_sign;

  logic             r_busy;
  logic             r_done;
  logic [W-2:0]     r_min_mag;
  logic [W-2:0]     r_second_mag;
  logic [IDX_W-1:0] r_min_pos;
  logic             r_sign_prod;

  logic [W-2:0]     w_mag;
  logic [W-2:0]     w_nxt_min;
  logic [W-2:0]     w_nxt_second;
  logic [IDX_W-1:0] w_nxt_pos;
  logic             w_nxt_sign;

  assign w_mag      = bus.in_data[W-2:0];
  assign w_nxt_sign = r_sign ^ bus.in_data[W-1];

  // Strict less-than against min: an equal magnitude never displaces the
  // current minimum, so min_pos keeps the first occurrence and the duplicate
  // falls through to the second-min slot.
  always_comb begin
    w_nxt_min    = r_min;
    w_nxt_second = r_second;
    w_nxt_pos    = r_pos;
    if (w_mag < r_min) begin
      w_nxt_second = r_min;
      w_nxt_min    = w_mag;
      w_nxt_pos    = r_cnt;
    end else if (w_mag < r_second) begin
      w_nxt_second = w_mag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_min        <= c_ones;
      r_second     <= c_ones;
      r_pos        <= '0;
      r_sign       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_min_mag    <= '0;
      r_second_mag <= '0;
      r_min_pos    <= '0;
      r_sign_prod  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state  <= ACCUM;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_min    <= c_ones;
            r_second <= c_ones;
            r_pos    <= '0;
            r_sign   <= 1'b0;
          end
        end

        ACCUM: begin
          if (bus.in_valid) begin
            r_min    <= w_nxt_min;
            r_second <= w_nxt_second;
            r_pos    <= w_nxt_pos;
            r_sign   <= w_nxt_sign;
            r_cnt    <= r_cnt + 1'b1;
            // Results are taken from the next-state values so the last beat
            // is folded in on the same edge that ends the row.
            if (r_cnt == c_last) begin
              r_state      <= DONE;
              r_done       <= 1'b1;
              r_min_mag    <= w_nxt_min;
              r_second_mag <= w_nxt_second;
              r_min_pos    <= w_nxt_pos;
              r_sign_prod  <= w_nxt_sign;
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.min_mag    = r_min_mag;
  assign bus.second_mag = r_second_mag;
  assign bus.min_pos    = r_min_pos;
  assign bus.sign_prod  = r_sign_prod;

endmodule
`default_nettype wire
